// File: rtl/data_bus_responder_pkg.sv
// Shared constants and types for the data-bus responder: config window offsets,
// fixed read values and the registered read-source select.
package data_bus_responder_pkg;

  localparam logic [31:0] CONF_BASE_DEFAULT = 32'hbfaf_0000;

  localparam logic [15:0] CONF_LED_ADDR    = 16'hf000;
  localparam logic [15:0] CONF_TIMER_ADDR  = 16'hf020;
  localparam logic [15:0] CONF_SWITCH_ADDR = 16'hf030;
  localparam logic [15:0] CONF_SIMU_ADDR   = 16'hf040;

  localparam logic [31:0] SIMU_FLAG_VALUE = 32'hffff_ffff;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_CONF
  } rd_sel_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  we);
    logic [31:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_bus_responder_data_ram.sv
// Byte-writable, read-first, single-port synchronous word RAM.
module data_ram #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// CPU data SRAM responder: word RAM plus LED/switch/simu-flag/timer config window.
// Optional timer is built when DATA_BUS_TIMER_EN is defined.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [31:0] CONF_BASE = CONF_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led
);

  logic        conf_hit;
  logic        conf_wr;
  logic        ram_en;
  logic [13:0] conf_word;
  logic [31:0] conf_read;
  logic [31:0] conf_rdata;
  logic [31:0] ram_rdata;
  rd_sel_e     rd_sel;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^data_sram_addr[1:0];

  assign conf_hit  = (data_sram_addr[31:16] == CONF_BASE[31:16]);
  assign conf_word = data_sram_addr[15:2];
  assign conf_wr   = data_sram_en && conf_hit && (data_sram_we != 4'b0000);
  // Gating with resetn drops a request that arrives during a reset cycle.
  assign ram_en    = resetn && data_sram_en && !conf_hit;

  data_ram #(
    .ADDR_W(ADDR_W)
  ) u_data_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (data_sram_we),
    .addr (data_sram_addr[ADDR_W+1:2]),
    .wdata(data_sram_wdata),
    .rdata(ram_rdata)
  );

`ifdef DATA_BUS_TIMER_EN
  logic [31:0] timer;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer <= '0;
    end else if (conf_wr && conf_word == CONF_TIMER_ADDR[15:2]) begin
      timer <= byte_merge(timer, data_sram_wdata, data_sram_we);
    end else begin
      timer <= timer + 32'd1;
    end
  end
`endif

  always_comb begin
    conf_read = '0;
    case (conf_word)
      CONF_LED_ADDR[15:2]:    conf_read = {16'h0000, led};
`ifdef DATA_BUS_TIMER_EN
      CONF_TIMER_ADDR[15:2]:  conf_read = timer;
`endif
      CONF_SWITCH_ADDR[15:2]: conf_read = {24'h000000, switch};
      CONF_SIMU_ADDR[15:2]:   conf_read = SIMU_FLAG_VALUE;
      default:                conf_read = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_sel     <= SEL_NONE;
      conf_rdata <= '0;
      led        <= '0;
    end else if (data_sram_en) begin
      rd_sel     <= conf_hit ? SEL_CONF : SEL_RAM;
      conf_rdata <= conf_read;
      if (conf_wr && conf_word == CONF_LED_ADDR[15:2]) begin
        for (int unsigned i = 0; i < 2; i++) begin
          if (data_sram_we[i]) led[8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Both sources are registered; the select reg picks which one the last request used.
  always_comb begin
    data_sram_rdata = '0;
    case (rd_sel)
      SEL_RAM:  data_sram_rdata = ram_rdata;
      SEL_CONF: data_sram_rdata = conf_rdata;
      default:  data_sram_rdata = '0;
    endcase
  end

endmodule
